// File: rtl/rom24_pkg.sv
// Shared constants and types for the 24x8 ROM burst reader.
// Three 8-word banks are addressed as one 24-word space.
package rom24_pkg;

  localparam int ROM_WORDS  = 24;
  localparam int BANK_DEPTH = 8;
  localparam int NUM_ROMS   = 3;
  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Successor of a global address, wrapping at the top of the ROM.
  function automatic logic [ADDR_W-1:0] next_addr(
    input logic [ADDR_W-1:0] a
  );
    return (a == ADDR_W'(ROM_WORDS - 1)) ? '0 : a + 1'b1;
  endfunction

endpackage

// File: rtl/rom24_addr_decode.sv
// Splits a global address into a one-hot bank select and bank offset.
// hit_o flags addresses inside the 24-word space regardless of enable.
module rom24_addr_decode
  import rom24_pkg::*;
(
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic                en_i,
  output logic [NUM_ROMS-1:0] cs_o,
  output logic [2:0]          addrb_o,
  output logic                hit_o
);

  logic [1:0] bank;

  assign bank    = addr_i[4:3];
  assign hit_o   = (addr_i < ADDR_W'(ROM_WORDS));
  assign addrb_o = en_i ? addr_i[2:0] : 3'd0;

  always_comb begin
    cs_o = '0;
    if (en_i && hit_o) begin
      cs_o = NUM_ROMS'(3'b001 << bank);
    end
  end

endmodule

// File: rtl/rom24_burst_reader.sv
// Burst read controller for the three-bank 24x8 ROM with a
// valid/ready output stage and modulo-24 address walk.
module rom24_burst_reader
  import rom24_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [ADDR_W-1:0]   burst_len,
  output logic                busy,
  output logic [NUM_ROMS-1:0] cs,
  output logic [2:0]          addrb,
  output logic                read_en,
  input  logic [DATA_W-1:0]   datab0,
  input  logic [DATA_W-1:0]   datab1,
  input  logic [DATA_W-1:0]   datab2,
  output logic [DATA_W-1:0]   dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                done,
  output logic                err
);

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   addr_d;
  logic [ADDR_W-1:0]   rem_q;
  logic [DATA_W-1:0]   dout_q;
  logic                valid_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

  logic                issue;
  logic                hit;
  logic                req_ok;
  logic [ADDR_W-1:0]   dec_addr;

  assign issue = (state_q == READ) && (!valid_q || dout_ready);

  // One decoder serves both the range check in IDLE and bank selection.
  assign dec_addr = (state_q == IDLE) ? start_addr : addr_q;

  rom24_addr_decode u_dec (
    .addr_i  (dec_addr),
    .en_i    (issue),
    .cs_o    (cs),
    .addrb_o (addrb),
    .hit_o   (hit)
  );

  assign req_ok = hit
               && (burst_len != '0)
               && (burst_len <= ADDR_W'(ROM_WORDS));

  assign addr_d = next_addr(addr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (req_ok) begin
              addr_q  <= start_addr;
              rem_q   <= burst_len;
              busy_q  <= 1'b1;
              state_q <= READ;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue) begin
            dout_q  <= datab0 | datab1 | datab2;
            valid_q <= 1'b1;
            addr_q  <= addr_d;
            rem_q   <= rem_q - 1'b1;
            if (rem_q == ADDR_W'(1)) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (valid_q && dout_ready) begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign read_en    = issue;
  assign busy       = busy_q;
  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_rom24_burst_reader.sv
// Randomised bench for rom24_burst_reader against a queue-based
// model of the expected address and data streams.
module tb_rom24_burst_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] start_addr;
  logic [4:0] burst_len;
  logic       busy;
  logic [2:0] cs;
  logic [2:0] addrb;
  logic       read_en;
  logic [7:0] datab0, datab1, datab2;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       done;
  logic       err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rom24_burst_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .burst_len  (burst_len),
    .busy       (busy),
    .cs         (cs),
    .addrb      (addrb),
    .read_en    (read_en),
    .datab0     (datab0),
    .datab1     (datab1),
    .datab2     (datab2),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .done       (done),
    .err        (err)
  );

  // ROM contents: bank k, offset j holds 64*k + 10*j.
  function automatic int rom_word(input int a);
    return 64 * (a / 8) + 10 * (a % 8);
  endfunction

  always_comb begin
    datab0 = cs[0] ? 8'(rom_word(0  + int'(addrb))) : 8'd0;
    datab1 = cs[1] ? 8'(rom_word(8  + int'(addrb))) : 8'd0;
    datab2 = cs[2] ? 8'(rom_word(16 + int'(addrb))) : 8'd0;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // mode 0: ready high, 1: random ready, 2: 3-cycle stall after first capture
  task automatic run_burst(input int sa, input int len, input int mode,
                           input bit mid_start);
    int  aq[$];
    int  dq[$];
    int  a;
    int  stall_left;
    bit  fin;
    bit  was_stall;
    int  prev_dout;
    for (int i = 0; i < len; i++) begin
      a = (sa + i) % 24;
      aq.push_back(a);
      dq.push_back(rom_word(a));
    end
    stall_left = -1;
    fin        = 0;
    was_stall  = 0;
    prev_dout  = 0;
    start      = 1'b1;
    start_addr = 5'(sa);
    burst_len  = 5'(len);
    dout_ready = 1'b1;
    #1;
    chk("idle_rd", int'(read_en), 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_up", int'(busy), 1);
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      case (mode)
        1: dout_ready = 1'($urandom_range(0, 1));
        2: begin
          if (dout_valid && stall_left < 0) stall_left = 3;
          dout_ready = !(stall_left > 0);
          if (stall_left > 0) stall_left--;
        end
        default: dout_ready = 1'b1;
      endcase
      if (mid_start && busy && $urandom_range(0, 2) == 0) begin
        start      = 1'b1;
        start_addr = 5'($urandom_range(0, 31));
        burst_len  = 5'($urandom_range(0, 31));
      end else begin
        start = 1'b0;
      end
      #1;
      if (read_en) begin
        if (aq.size() == 0) begin
          chk("extra_rd", 1, 0);
        end else begin
          a = aq.pop_front();
          chk("cs", int'(cs), 1 << (a / 8));
          chk("addrb", int'(addrb), a % 8);
        end
      end else begin
        chk("cs_off", int'(cs), 0);
      end
      if (dout_valid && !dout_ready) chk("stall_rd", int'(read_en), 0);
      if (was_stall) begin
        chk("hold_valid", int'(dout_valid), 1);
        chk("hold_dout", int'(dout), prev_dout);
      end
      chk("no_err", int'(err), 0);
      if (done) begin
        fin = 1;
        chk("done_last", dq.size(), 0);
      end
      if (dout_valid && dout_ready) begin
        if (dq.size() == 0) chk("extra_word", 1, 0);
        else chk("dout", int'(dout), dq.pop_front());
      end
      was_stall = dout_valid && !dout_ready;
      prev_dout = int'(dout);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("done_seen", int'(fin), 1);
    chk("busy_end", int'(busy), 0);
    chk("reads_left", aq.size(), 0);
    chk("done_once", int'(done), 0);
    @(posedge clk); #1;
  endtask

  task automatic bad_req(input int sa, input int len);
    start      = 1'b1;
    start_addr = 5'(sa);
    burst_len  = 5'(len);
    dout_ready = 1'b1;
    #1;
    chk("bad_rd", int'(read_en), 0);
    chk("bad_cs", int'(cs), 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("bad_err", int'(err), 1);
    chk("bad_busy", int'(busy), 0);
    chk("bad_rd2", int'(read_en), 0);
    @(posedge clk); #1;
    chk("bad_err_clr", int'(err), 0);
    chk("bad_busy2", int'(busy), 0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    burst_len  = '0;
    dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(dout_valid), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_rd", int'(read_en), 0);
    chk("rst_cs", int'(cs), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_burst(16, 3, 0, 0);
    run_burst(22, 4, 0, 0);
    run_burst(20, 2, 2, 0);
    bad_req(5, 0);
    bad_req(24, 3);
    bad_req(0, 25);
    bad_req(31, 1);
    run_burst(0, 24, 0, 1);
    run_burst(23, 24, 1, 1);
    for (int k = 0; k < 6; k++) begin
      run_burst(int'($urandom_range(0, 23)), int'($urandom_range(1, 24)),
                int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a burst.
    start      = 1'b1;
    start_addr = 5'd8;
    burst_len  = 5'd10;
    dout_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_rd", int'(read_en), 1);
    rst = 1'b1;
    #1;
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_rd", int'(read_en), 0);
    chk("mrst_cs", int'(cs), 0);
    chk("mrst_addrb", int'(addrb), 0);
    chk("mrst_valid", int'(dout_valid), 0);
    chk("mrst_dout", int'(dout), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("post_rst_done", int'(done), 0);
      chk("post_rst_busy", int'(busy), 0);
      chk("post_rst_rd", int'(read_en), 0);
    end
    run_burst(7, 5, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rom24_burst_reader.md
Name: rom24_burst_reader

Overview:
Sequential read controller that sits directly upstream of the three 8x8 ROM banks that form the 24x8 ROM.
- Accepts a burst request (start address, length) and walks global addresses 0..23, wrapping modulo 24.
- Decodes each address into a one-hot bank chip-select plus a 3-bit bank address, and pulses read_en.
- Captures the returned byte and presents it downstream on a valid/ready handshake with backpressure.

Parameters:
NUM_ROMS, 3, number of 8x8 banks
BANK_DEPTH, 8, words per bank
DATA_W, 8, data width
ADDR_W, 5, global address width (covers NUM_ROMS*BANK_DEPTH = 24 words)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  burst request; sampled only in IDLE
start_addr  in  ADDR_W  first global address
burst_len  in  ADDR_W  words to read, legal range 1..24
busy  out  1  high from accepted start until done
cs  out  NUM_ROMS  one-hot bank select; bit0 = bank for 0..7, bit2 = bank for 16..23
addrb  out  3  address within the selected bank
read_en  out  1  read strobe to all banks
datab0  in  DATA_W  data from bank 0 (bank outputs 0 when not selected)
datab1  in  DATA_W  data from bank 1
datab2  in  DATA_W  data from bank 2
dout  out  DATA_W  captured word
dout_valid  out  1  dout holds an unconsumed word
dout_ready  in  1  consumer accepts dout this cycle
done  out  1  one-cycle pulse when the last word of a burst is accepted
err  out  1  one-cycle pulse on an illegal request

Behaviour:
- Reset, asynchronous on rst: state=IDLE; addr, remaining, dout=0; dout_valid, busy, done, err=0. cs, addrb and read_en read 0 while rst is high.
- FSM states: IDLE, READ, DRAIN.
- IDLE, start=1:
  - If burst_len==0 or start_addr>=24: pulse err next cycle and stay IDLE. No bank is ever selected.
  - Otherwise: addr<=start_addr, remaining<=burst_len, busy<=1, go to READ.
- READ:
  - issue = !dout_valid || dout_ready.
  - When issue is high:
    - read_en=1 and cs=onehot(addr/8), addrb=addr%8, combinationally in the same cycle.
    - At the clock edge: dout<=datab0|datab1|datab2; dout_valid<=1; addr<=(addr==23)?0:addr+1; remaining<=remaining-1.
    - If remaining==1, go to DRAIN.
  - When issue is low: read_en=0 and cs=0; addr and remaining hold.
- Latency: a word is visible on dout one cycle after its read strobe. With dout_ready held high, throughput is 1 word per cycle.
- DRAIN: no reads. When dout_valid && dout_ready, clear dout_valid, pulse done, drop busy, go to IDLE.
- Handshake: dout and dout_valid are stable while dout_valid=1 and dout_ready=0. A word is transferred on a cycle where both are high. Accepting a word and capturing the next one in the same cycle is legal.
- start while busy: ignored. No err is raised.
- Wrap-around: address 23 is followed by address 0, and cs moves from bit2 to bit0.
- burst_len up to 24 is legal from any start address. burst_len greater than 24 pulses err.
- rst asserted mid-burst: the burst is abandoned immediately, all outputs return to reset values, and no done is produced.

Decomposition:
- Shared package rom24_pkg:
  - ROM_WORDS=24, BANK_DEPTH=8, NUM_ROMS=3.
  - State encoding IDLE=2'd0, READ=2'd1, DRAIN=2'd2.
- One sub-module, rom24_addr_decode: combinational, global addr[4:0] plus enable in, one-hot cs[2:0] and addrb[2:0] out. The top-level block also uses it to check start_addr range.

Test Plan:
- Reset mid-burst: assert rst during READ -> all outputs 0 in the same cycle; after release, busy=0 and no done pulse.
- Basic burst in bank 2: start_addr=16, burst_len=3, dout_ready=1 -> cs=3'b100, addrb=0,1,2 on 3 consecutive cycles; dout=128,138,148 one cycle later each; done pulses with the third transfer.
- Wrap-around: start_addr=22, burst_len=4, ready=1 -> cs=100,100,001,001 and addrb=6,7,0,1; dout=188,198 followed by the bank-0 model values at global addresses 0 and 1.
- Backpressure: start_addr=20, burst_len=2, ready low for 3 cycles after the first capture -> dout stays 168 with valid=1 and read_en=0 during the stall; 178 follows one cycle after ready rises.
- Illegal requests: burst_len=0, then start_addr=24 -> err pulses once for each; cs and read_en never assert; busy stays 0.
- Full sweep: start_addr=0, burst_len=24 -> 24 transfers over addresses 0..23 in order; start pulses issued mid-burst are ignored; one done pulse.
